serial_cmd_accumulator: RTL and testbench

//  Parametrised UART-side command engine; sits between the UART rx/tx cores and the board LEDs.

---
 rtl/serial_cmd_accumulator.sv | 200 ++++++++++++++++++++
 tb/tb_serial_cmd_accumulator.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_accumulator
// Description : UART-side command engine. It receives a command byte. For
//               CMD_ADD it then takes DATA_BYTES operand bytes, MSB first,
//               sign-extends the operand and adds it into an ACC_BYTES-wide
//               accumulator. CMD_CLR clears the accumulator instead. Either
//               command sends the accumulator back over tx, MSB first.
//               ledout mirrors acc[7:0].
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_rx_data        - received byte, qualified by i_new_rx_data
//               i_new_rx_data    - one-cycle strobe per received byte
//               o_tx_data        - byte to transmit, qualified by o_new_tx_data
//               o_new_tx_data    - one-cycle transmit strobe
//               i_tx_busy        - UART transmitter busy
//               o_ledout         - accumulator LSB
//               o_busy           - high whenever the FSM is not idle
//               o_err            - one-cycle pulse on a protocol error
// Options     : SERIAL_CMD_TIMEOUT_EN - when defined, RECV aborts after
//               TIMEOUT_CYCLES cycles without a received byte
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmd_accumulator #(
    parameter int         DATA_BYTES     = 4,
    parameter int         ACC_BYTES      = 4,
    parameter logic [7:0] CMD_ADD        = 8'h68,
    parameter logic [7:0] CMD_CLR        = 8'h63,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_new_rx_data,
    output logic [7:0] o_tx_data,
    output logic       o_new_tx_data,
    input  logic       i_tx_busy,
    output logic [7:0] o_ledout,
    output logic       o_busy,
    output logic       o_err
);

    localparam int         c_OPW      = 8 * DATA_BYTES;
    localparam int         c_ACCW     = 8 * ACC_BYTES;
    localparam logic [3:0] c_LAST_CNT = 4'(DATA_BYTES - 1);
    localparam logic [2:0] c_TOP_IDX  = 3'(ACC_BYTES - 1);

    // Elaboration-time parameter sanity checks
    if (DATA_BYTES < 1 || DATA_BYTES > 8) begin : g_bad_data_bytes
        $error("DATA_BYTES must be in 1..8");
    end
    if (ACC_BYTES < DATA_BYTES || ACC_BYTES > 8) begin : g_bad_acc_bytes
        $error("ACC_BYTES must be in DATA_BYTES..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_EXEC = 3'd2,
        S_SEND = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_ACCW-1:0]   r_acc;
    logic [c_OPW-1:0]    r_operand;
    logic [3:0]          r_count;
    logic [2:0]          r_idx;
    logic [7:0]          r_tx_data;
    logic                r_new_tx;
    logic                r_err;

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int              c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0] r_tmo;
`endif

    logic [c_OPW-1:0]  w_opnd_shift;
    logic [c_ACCW-1:0] w_opnd_ext;
    logic [7:0]        w_tx_byte;

    // Shift works for every DATA_BYTES, including the single-byte case
    assign w_opnd_shift = (r_operand << 8) | c_OPW'(i_rx_data);
    assign w_opnd_ext   = c_ACCW'($signed(r_operand));

    // Byte select with constant part-select bounds
    always_comb begin
        w_tx_byte = 8'h00;
        for (int b = 0; b < ACC_BYTES; b++) begin
            if (r_idx == 3'(b)) begin
                w_tx_byte = r_acc[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_operand <= '0;
            r_count   <= 4'd0;
            r_idx     <= 3'd0;
            r_tx_data <= 8'h00;
            r_new_tx  <= 1'b0;
            r_err     <= 1'b0;
`ifdef SERIAL_CMD_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            r_new_tx <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_new_rx_data) begin
                        if (i_rx_data == CMD_ADD) begin
                            r_count   <= 4'd0;
                            r_operand <= '0;
                            r_state   <= S_RECV;
                        end else if (i_rx_data == CMD_CLR) begin
                            r_acc   <= '0;
                            r_idx   <= c_TOP_IDX;
                            r_state <= S_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    // Every byte here is operand data, even command values
                    if (i_new_rx_data) begin
                        r_operand <= w_opnd_shift;
                        r_count   <= r_count + 4'd1;
`ifdef SERIAL_CMD_TIMEOUT_EN
                        r_tmo     <= '0;
`endif
                        if (r_count == c_LAST_CNT) begin
                            r_state <= S_EXEC;
                        end
                    end
`ifdef SERIAL_CMD_TIMEOUT_EN
                    else if (r_tmo == c_TMO_LAST) begin
                        r_tmo     <= '0;
                        r_operand <= '0;
                        r_count   <= 4'd0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_EXEC: begin
                    if (i_new_rx_data) begin
                        r_err <= 1'b1;
                    end
                    r_acc   <= r_acc + w_opnd_ext;
                    r_idx   <= c_TOP_IDX;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (i_new_rx_data) begin
                        r_err <= 1'b1;
                    end
                    // While stalled, r_tx_data keeps the last byte sent
                    if (!i_tx_busy) begin
                        r_new_tx  <= 1'b1;
                        r_tx_data <= w_tx_byte;
                        if (r_idx == 3'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx - 3'd1;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // Dead cycle gives the UART time to raise tx_busy
                    if (i_new_rx_data) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_SEND;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_new_tx_data = r_new_tx;
    assign o_err         = r_err;
    assign o_ledout      = r_acc[7:0];
    assign o_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cmd_accumulator
// Description : Directed self-checking bench for serial_cmd_accumulator.
//               Main instance: 4-byte operand, 4-byte accumulator, with a
//               UART model on tx_busy. Second instance: 2-byte operand, used
//               for the sign-extension case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cmd_accumulator;

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int c_TMO = 20;
`else
    localparam int c_TMO = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx;
    logic [7:0] tx_data;
    logic       new_tx;
    logic       tx_busy;
    logic [7:0] ledout;
    logic       busy;
    logic       err;

    logic [7:0] rx2;
    logic       new_rx2;
    logic [7:0] tx2;
    logic       new_tx2;
    logic [7:0] led2;
    logic       busy2;
    logic       err2;

    always #5 clk = ~clk;

    serial_cmd_accumulator #(
        .DATA_BYTES(4), .ACC_BYTES(4), .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(rx_data), .i_new_rx_data(new_rx),
        .o_tx_data(tx_data), .o_new_tx_data(new_tx),
        .i_tx_busy(tx_busy),
        .o_ledout(ledout), .o_busy(busy), .o_err(err)
    );

    serial_cmd_accumulator #(
        .DATA_BYTES(2), .ACC_BYTES(4)
    ) dut2 (
        .clk(clk), .rst(rst),
        .i_rx_data(rx2), .i_new_rx_data(new_rx2),
        .o_tx_data(tx2), .o_new_tx_data(new_tx2),
        .i_tx_busy(1'b0),
        .o_ledout(led2), .o_busy(busy2), .o_err(err2)
    );

    // UART model: busy rises the cycle after a transmit strobe, for 4 cycles
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    assign tx_busy = force_busy | (busy_cnt != 0);
    always @(posedge clk) begin
        if (new_tx)             busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Monitors
    logic [7:0] q_tx[$];
    logic [7:0] q_tx2[$];
    int   err_cnt  = 0;
    bit   consec   = 1'b0;
    logic prev_new = 1'b0;
    always @(negedge clk) begin
        if (new_tx) begin
            q_tx.push_back(tx_data);
            if (prev_new) consec = 1'b1;
        end
        prev_new = new_tx;
        if (err) err_cnt++;
        if (new_tx2) q_tx2.push_back(tx2);
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b;
        new_rx  = 1'b1;
        tick();
        new_rx  = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        tick();
        rx2     = b;
        new_rx2 = 1'b1;
        tick();
        new_rx2 = 1'b0;
    endtask

    task automatic wait_done(input bit second);
        int n;
        n = 0;
        while (n < 300 && (second ? (q_tx2.size() < 4 || busy2) : (q_tx.size() < 4 || busy))) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL reply_timeout: got %0d bytes, required 4", second ? q_tx2.size() : q_tx.size());
        end
    endtask

    task automatic wait_first();
        int n;
        n = 0;
        while (n < 50 && q_tx.size() < 1) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL first_byte_timeout: no transmit strobe within 50 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'h00; new_rx = 1'b0; rx2 = 8'h00; new_rx2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({tx_data, new_tx, ledout, busy, err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {tx_data, new_tx, ledout, busy, err});
        end
        checks++;
        if ({tx2, new_tx2, led2, busy2, err2} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs2: got %h, required 0", {tx2, new_tx2, led2, busy2, err2});
        end
    endtask

    task automatic test_add_first();
        logic [31:0] exp;
        exp = 32'hB108_0000;
        q_tx.delete(); consec = 1'b0;
        send_byte(8'h68); send_byte(8'hB1); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        tick();
        checks++;
        if (new_tx !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: new_tx_data=%b one cycle after last byte, required 0", new_tx);
        end
        tick();
        checks++;
        if (new_tx !== 1'b1 || tx_data !== 8'hB1) begin
            errors++;
            $display("FAIL latency_first: new_tx_data=%b tx_data=%h, required 1/B1", new_tx, tx_data);
        end
        wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_tx.size() <= i || q_tx[i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL add1_byte%0d: got %h, required %h", i, q_tx.size() > i ? q_tx[i] : 8'hxx, exp[31-8*i -: 8]);
            end
        end
        checks++;
        if (ledout !== 8'h00 || consec !== 1'b0) begin
            errors++;
            $display("FAIL add1_led_gap: ledout=%h consecutive=%b, required 00/0", ledout, consec);
        end
    endtask

    task automatic test_add_wrap();
        logic [31:0] exp;
        exp = 32'hB307_FFFF;
        q_tx.delete();
        send_byte(8'h68); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        tick();
        checks++;
        if (ledout !== 8'hFF) begin
            errors++;
            $display("FAIL add2_led_timing: ledout=%h with acc update, required FF", ledout);
        end
        wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_tx.size() <= i || q_tx[i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL add2_byte%0d: got %h, required %h", i, q_tx.size() > i ? q_tx[i] : 8'hxx, exp[31-8*i -: 8]);
            end
        end
    endtask

    task automatic test_clear();
        q_tx.delete();
        send_byte(8'h63);
        wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_tx.size() <= i || q_tx[i] !== 8'h00) begin
                errors++;
                $display("FAIL clr_byte%0d: got %h, required 00", i, q_tx.size() > i ? q_tx[i] : 8'hxx);
            end
        end
        checks++;
        if (ledout !== 8'h00 || q_tx.size() != 4) begin
            errors++;
            $display("FAIL clr_led: ledout=%h bytes=%0d, required 00/4", ledout, q_tx.size());
        end
    endtask

    task automatic test_sign_ext();
        logic [31:0] exp;
        exp = 32'hFFFF_FFFE;
        q_tx2.delete();
        send_byte2(8'h68); send_byte2(8'hFF); send_byte2(8'hFE);
        wait_done(1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_tx2.size() <= i || q_tx2[i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL sext_byte%0d: got %h, required %h", i, q_tx2.size() > i ? q_tx2[i] : 8'hxx, exp[31-8*i -: 8]);
            end
        end
        checks++;
        if (led2 !== 8'hFE) begin
            errors++;
            $display("FAIL sext_led: got %h, required FE", led2);
        end
    endtask

    task automatic test_bad_header();
        bit busy_seen;
        busy_seen = 1'b0;
        q_tx.delete(); err_cnt = 0;
        send_byte(8'h78);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL bad_hdr_err: err high for %0d cycles, required 1", err_cnt);
        end
        checks++;
        if (busy_seen || q_tx.size() != 0) begin
            errors++;
            $display("FAIL bad_hdr_quiet: busy_seen=%b tx_bytes=%0d, required 0/0", busy_seen, q_tx.size());
        end
    endtask

    task automatic test_strobe_in_send();
        q_tx.delete(); err_cnt = 0;
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        wait_first();
        send_byte(8'h63);
        wait_done(1'b0);
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL send_strobe_err: err cycles=%0d, required 1", err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_tx.size() <= i || q_tx[i] !== (i == 3 ? 8'h05 : 8'h00)) begin
                errors++;
                $display("FAIL send_strobe_byte%0d: got %h, required %h", i, q_tx.size() > i ? q_tx[i] : 8'hxx, i == 3 ? 8'h05 : 8'h00);
            end
        end
        // Adding zero reports the accumulator, which must still be 5
        q_tx.delete();
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done(1'b0);
        checks++;
        if (q_tx.size() != 4 || {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} !== 32'h0000_0005) begin
            errors++;
            $display("FAIL send_strobe_acc: got %h, required 00000005", q_tx.size() == 4 ? {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} : 32'hx);
        end
    endtask

    task automatic test_tx_stall();
        bit bad_hold;
        bad_hold = 1'b0;
        q_tx.delete(); consec = 1'b0;
        force_busy = 1'b1;
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        repeat (50) tick();
        checks++;
        if (q_tx.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_start: tx_bytes=%0d busy=%b, required 0/1", q_tx.size(), busy);
        end
        force_busy = 1'b0;
        wait_first();
        force_busy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_data !== 8'h00) bad_hold = 1'b1;
        end
        checks++;
        if (bad_hold || q_tx.size() != 1) begin
            errors++;
            $display("FAIL stall_hold: changed=%b tx_bytes=%0d, required 0/1", bad_hold, q_tx.size());
        end
        force_busy = 1'b0;
        wait_done(1'b0);
        checks++;
        if (q_tx.size() != 4 || {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} !== 32'h0000_000C || consec) begin
            errors++;
            $display("FAIL stall_reply: got %h consecutive=%b, required 0000000C/0", q_tx.size() == 4 ? {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} : 32'hx, consec);
        end
    endtask

    task automatic test_rst_mid_send();
        q_tx.delete();
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        wait_first();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({tx_data, new_tx, ledout, busy, err} !== 19'd0) begin
            errors++;
            $display("FAIL rst_send_outputs: got %h, required 0", {tx_data, new_tx, ledout, busy, err});
        end
        repeat (20) tick();
        checks++;
        if (q_tx.size() != 1) begin
            errors++;
            $display("FAIL rst_send_discard: tx_bytes=%0d, required 1", q_tx.size());
        end
        q_tx.delete();
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done(1'b0);
        checks++;
        if (q_tx.size() != 4 || {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} !== 32'h0) begin
            errors++;
            $display("FAIL rst_send_acc: got %h, required 00000000", q_tx.size() == 4 ? {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} : 32'hx);
        end
    endtask

`ifdef SERIAL_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        send_byte(8'h68); send_byte(8'h12);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (err && n == 0) n = k;
        end
        checks++;
        if (n != 20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err at cycle %0d busy=%b, required 20/0", n, busy);
        end
        q_tx.delete();
        send_byte(8'h68); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        wait_done(1'b0);
        checks++;
        if (q_tx.size() != 4 || {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} !== 32'h0000_0005) begin
            errors++;
            $display("FAIL timeout_acc: got %h, required 00000005", q_tx.size() == 4 ? {q_tx[0], q_tx[1], q_tx[2], q_tx[3]} : 32'hx);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_first();
        test_add_wrap();
        test_clear();
        test_sign_ext();
        test_bad_header();
        test_strobe_in_send();
        test_tx_stall();
        test_rst_mid_send();
`ifdef SERIAL_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
